fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream drain stage for the 8-deep byte FIFO: pops one byte at a time when the FIFO is non-empty
//  and serialises it as an 8N1 UART frame on tx (LSB first). Sits between the FIFO read port and the pad.
//  Owns the FIFO read strobe; the FIFO is never read while a frame is in flight.
// PARAMETERS
//  DATA_W        8    byte width; must match FIFO data width
//  CLKS_PER_BIT  16   clk cycles per UART bit (>=2)
//  DIV_W         8    width of the baud divider counter; must hold CLKS_PER_BIT-1
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       synchronous reset, active-high
//  en          in   1       allow new frames to start; an in-flight frame always completes
//  fifo_data   in   DATA_W  FIFO read data (valid the cycle after fifo_rd_en was sampled high)
//  fifo_empty  in   1       FIFO empty flag
//  fifo_rd_en  out  1       FIFO pop strobe, registered, exactly one cycle per byte
//  tx          out  1       serial line, idle high
//  busy        out  1       high in every state except IDLE
//  tx_done     out  1       one-cycle pulse in the final cycle of the stop bit
//  sent_cnt    out  16      frames completed, wraps 0xFFFF->0x0000
// BEHAVIOUR
//  Reset values: fifo_rd_en=0, tx=1, busy=0, tx_done=0, sent_cnt=0, state=IDLE, counters=0.
//  FSM states: IDLE, FETCH, LOAD, START, DATA, [PARITY], STOP.
//  IDLE:   if en && !fifo_empty -> FETCH, else stay. tx=1.
//  FETCH:  fifo_rd_en=1 for this single cycle -> LOAD. tx=1.
//  LOAD:   shift register <= fifo_data at the closing edge -> START. tx=1.
//  START:  tx=0 for CLKS_PER_BIT cycles -> DATA.
//  DATA:   tx=shreg[0], shift right each bit period, bit index 0..DATA_W-1 -> PARITY or STOP.
//  STOP:   tx=1 for CLKS_PER_BIT cycles; tx_done and sent_cnt++ on the last cycle -> IDLE (always).
//  Frame latency: FETCH-cycle to stop end = 2 + (DATA_W+2[+1])*CLKS_PER_BIT cycles.
//  Back-to-back: minimum 3 cycles of idle-high (IDLE, FETCH, LOAD) between stop end and the next start.
//  fifo_empty is sampled only in IDLE; changes at any other time are ignored.
//  en low mid-frame: the frame finishes; the next frame is not started until en is high in IDLE.
//  fifo_rd_en is never asserted while fifo_empty=1 at the IDLE decision; no pop while busy.
//  rst mid-frame: tx high at the next edge, the byte is discarded, and the FIFO is not re-read.
//  The baud divider reloads at every state entry so that each bit lasts exactly CLKS_PER_BIT cycles.
// CONFIGURATION
//  Macro FIFO_UART_TX_PARITY_EN:
//   defined   -> PARITY state after DATA: tx = even parity (XOR of the data bits) for one bit period.
//                Frame is 11 bits.
//   undefined -> DATA goes directly to STOP; the PARITY state and its logic are not compiled in.
//                Frame is 10 bits.
// STRUCTURE
//  Package fifo_uart_tx_pkg: state encodings (localparam), frame-length constant, and default
//  CLKS_PER_BIT.
//  Sub-module uart_baud_gen: down-counter with load input, emits bit_end when it reaches 0.
//  The FSM, shift register and bit index stay in the top module.
// TESTING  (CLKS_PER_BIT=4, paired with the 8-deep FIFO model)
//  1 Reset, FIFO empty, en=1 for 100 cycles -> tx stays 1; fifo_rd_en, busy and tx_done stay 0.
//  2 Push 0xA5 -> single fifo_rd_en pulse; tx = 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit;
//    tx_done pulses once; sent_cnt=1.
//  3 Push 0x01,0x02,0x03 together -> three frames with exactly 3 idle-high cycles between them;
//    FIFO drains to empty; sent_cnt=3.
//  4 en=0 during bit 3 of frame 0x5A with 0x77 queued -> 0x5A completes; 0x77 waits until en
//    returns, then one pop.
//  5 rst during the DATA state -> next edge tx=1, busy=0; no extra pop; the queued byte is sent
//    after rst is released.
//  6 With the macro defined, send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1; frame is
//    11 bits (44 cycles).

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared constants for the FIFO drain UART transmitter: FSM encodings, frame length, default baud divide.
// Frame length grows by one bit when FIFO_UART_TX_PARITY_EN is defined.
package fifo_uart_tx_pkg;

  // Ordered so that every bit-timed state compares >= ST_START.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam int DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: reloads to CLKS_PER_BIT-1 on load, counts down, flags bit_end at zero.
// Latency: bit_end is combinational from the counter; no backpressure, load always wins.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DIV_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic bit_end
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLKS_PER_BIT - 1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign bit_end = (cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage sending each byte as an 8N1 frame (8E1 when FIFO_UART_TX_PARITY_EN is defined) on tx.
// Latency 2 + FRAME_BITS*CLKS_PER_BIT cycles from FETCH to stop end; pops only from IDLE, en gates frame start.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DIV_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic [15:0]       sent_cnt
);

  localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic [2:0]        state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [IDX_W-1:0]  bit_idx, idx_nxt;
  logic              tx_nxt;
  logic              bit_end;
  logic              baud_load;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              par, par_nxt;
`endif

  // Reload on every state change and at each bit boundary inside the timed states.
  assign baud_load = (state_nxt != state) || ((state >= ST_START) && bit_end);
  assign tx_done   = (state == ST_STOP) && bit_end;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DIV_W        (DIV_W)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .load    (baud_load),
    .bit_end (bit_end)
  );

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    idx_nxt   = bit_idx;
`ifdef FIFO_UART_TX_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      ST_IDLE:  if (en && !fifo_empty) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD: begin
        shreg_nxt = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
        par_nxt   = ^fifo_data;
`endif
        state_nxt = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          idx_nxt   = '0;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_nxt = shreg >> 1;
          if (bit_idx == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
`endif
      ST_STOP:  if (bit_end) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // tx is registered from the next state so the pad never sees decode glitches.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shreg_nxt[0];
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: tx_nxt = par_nxt;
`endif
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      fifo_rd_en <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      sent_cnt   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_idx    <= idx_nxt;
      fifo_rd_en <= (state_nxt == ST_FETCH);
      tx         <= tx_nxt;
      busy       <= (state_nxt != ST_IDLE);
`ifdef FIFO_UART_TX_PARITY_EN
      par        <= par_nxt;
`endif
      if (tx_done) sent_cnt <= sent_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with CLKS_PER_BIT=4 against an 8-deep FIFO model and a tx line receiver.
// Expected bytes are queued at push time and popped as frames are decoded.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
  import fifo_uart_tx_pkg::*;

  localparam int CPB = 4;
  localparam int NB  = FRAME_BITS;
  localparam int GAP = NB * CPB + 3;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        en         = 1'b0;
  logic [7:0]  fifo_data  = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic        tx_done;
  logic [15:0] sent_cnt;

  fifo_uart_tx #(
    .DATA_W       (8),
    .CLKS_PER_BIT (CPB),
    .DIV_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .sent_cnt   (sent_cnt)
  );

  always #5 clk = ~clk;

  int total    = 0;
  int bad      = 0;
  int exp_sent = 0;
  int rx_rd    = 0;
  logic [7:0] exp_q[$];

  // 8-deep FIFO model: registered read data and empty flag.
  logic       push_vld = 1'b0;
  logic [7:0] push_dat = 8'h00;
  logic [7:0] fq[$];
  int         pop_empty = 0;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() == 0) pop_empty++;
      else fifo_data <= fq.pop_front();
    end
    if (push_vld && fq.size() < 8) fq.push_back(push_dat);
    fifo_empty <= (fq.size() == 0);
  end

  // Line monitor and receiver, sampling on the falling edge.
  int         cyc = 0;
  int         rd_pulses = 0;
  int         done_pulses = 0;
  logic       rx_on = 1'b0;
  int         rx_s = 0;
  int         rx_k = 0;
  int         rx_t0 = 0;
  logic [7:0] rx_sh = 8'h00;
  logic       rx_p = 1'b0;
  logic [7:0] rx_dat[$];
  logic       rx_par[$];
  logic       rx_stop[$];
  int         rx_t[$];

  always @(negedge clk) begin
    cyc++;
    if (fifo_rd_en) rd_pulses++;
    if (tx_done) done_pulses++;
    if (rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1'b1;
        rx_s  = 0;
        rx_t0 = cyc;
      end
    end else begin
      rx_s++;
      if (rx_s % CPB == CPB / 2) begin
        rx_k = rx_s / CPB;
        if (rx_k == NB - 1) begin
          rx_dat.push_back(rx_sh);
          rx_par.push_back(rx_p);
          rx_stop.push_back(tx);
          rx_t.push_back(rx_t0);
          rx_on = 1'b0;
        end else if (rx_k >= 1 && rx_k <= 8) begin
          rx_sh[rx_k-1] = tx;
        end else if (rx_k == 9) begin
          rx_p = tx;
        end
      end
    end
  end

  function automatic logic exp_tx(input logic [7:0] b, input int c);
    int k;
    if (c < 2) return 1'b1;
    k = (c - 2) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && NB == 11) return ^b;
    return 1'b1;
  endfunction

  task automatic push1(input logic [7:0] b);
    push_vld = 1'b1;
    push_dat = b;
    exp_q.push_back(b);
    @(negedge clk);
    push_vld = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_dat.size() >= rx_rd + n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int viol;
    int rd0;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", fifo_rd_en); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_tx_done got=%b want=0", tx_done); end
    total++; if (sent_cnt !== 16'h0000) begin bad++; $display("FAIL reset_sent_cnt got=%0d want=0", sent_cnt); end
    rst = 1'b0;
    rd0 = rd_pulses;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || tx_done !== 1'b0) viol++;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL idle_empty violations got=%0d want=0", viol); end
    total++; if (rd_pulses != rd0) begin bad++; $display("FAIL idle_no_pop pops got=%0d want=0", rd_pulses - rd0); end
  endtask

  task automatic test_single();
    int   rd0;
    int   wave_err;
    int   done_err;
    int   first_c;
    bit   ok;
    logic [7:0] want;
    rd0 = rd_pulses;
    push1(8'hA5);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fifo_rd_en === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!ok) begin bad++; $display("FAIL single_fetch timeout got=none want=rd_en pulse"); end
    wave_err = 0;
    done_err = 0;
    first_c  = -1;
    for (int c = 0; c < 2 + NB * CPB; c++) begin
      if (tx !== exp_tx(8'hA5, c)) begin
        wave_err++;
        if (first_c < 0) first_c = c;
      end
      if (tx_done !== (c == 1 + NB * CPB)) done_err++;
      @(negedge clk);
    end
    total++; if (wave_err != 0) begin bad++; $display("FAIL single_wave errors got=%0d want=0 first_cycle=%0d", wave_err, first_c); end
    total++; if (done_err != 0) begin bad++; $display("FAIL single_tx_done_timing errors got=%0d want=0", done_err); end
    total++; if (busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL single_idle_after busy=%b tx=%b want busy=0 tx=1", busy, tx); end
    exp_sent++;
    total++; if (sent_cnt !== 16'(exp_sent)) begin bad++; $display("FAIL single_sent_cnt got=%0d want=%0d", sent_cnt, exp_sent); end
    total++; if (rd_pulses - rd0 != 1) begin bad++; $display("FAIL single_pops got=%0d want=1", rd_pulses - rd0); end
    wait_frames(1, 20, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL single_rx timeout got=no frame want=1 frame");
    end else begin
      want = exp_q.pop_front();
      if (rx_dat[rx_rd] !== want) begin bad++; $display("FAIL single_rx_data got=%h want=%h", rx_dat[rx_rd], want); end
      rx_rd++;
    end
  endtask

  task automatic test_back_to_back();
    int   rd0;
    int   d0;
    bit   ok;
    logic [7:0] want;
    rd0 = rd_pulses;
    d0  = done_pulses;
    push1(8'h01);
    push1(8'h02);
    push1(8'h03);
    wait_frames(3, 600, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_rx timeout got=%0d want=3 frames", rx_dat.size() - rx_rd); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        want = exp_q.pop_front();
        total++; if (rx_dat[rx_rd+i] !== want) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, rx_dat[rx_rd+i], want); end
        total++; if (rx_stop[rx_rd+i] !== 1'b1) begin bad++; $display("FAIL b2b_stop[%0d] got=%b want=1", i, rx_stop[rx_rd+i]); end
      end
      for (int i = 0; i < 2; i++) begin
        total++;
        if (rx_t[rx_rd+i+1] - rx_t[rx_rd+i] != GAP) begin
          bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=%0d", i, rx_t[rx_rd+i+1] - rx_t[rx_rd+i], GAP);
        end
      end
      rx_rd += 3;
    end
    repeat (10) @(negedge clk);
    exp_sent += 3;
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL b2b_drained fifo_empty got=%b want=1", fifo_empty); end
    total++; if (sent_cnt !== 16'(exp_sent)) begin bad++; $display("FAIL b2b_sent_cnt got=%0d want=%0d", sent_cnt, exp_sent); end
    total++; if (rd_pulses - rd0 != 3) begin bad++; $display("FAIL b2b_pops got=%0d want=3", rd_pulses - rd0); end
    total++; if (done_pulses - d0 != 3) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=3", done_pulses - d0); end
    total++; if (pop_empty != 0) begin bad++; $display("FAIL b2b_pop_on_empty got=%0d want=0", pop_empty); end
  endtask

  task automatic test_en_gate();
    int   rd0;
    bit   ok;
    logic [7:0] want;
    rd0 = rd_pulses;
    push1(8'h5A);
    push1(8'h77);
    wait_start(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL en_start timeout got=none want=start bit"); end
    repeat (4 * CPB + 1) @(negedge clk);
    en = 1'b0;
    wait_frames(1, 200, ok);
    repeat (20) @(negedge clk);
    total++;
    if (!ok) begin
      bad++; $display("FAIL en_rx timeout got=no frame want=5a");
    end else begin
      want = exp_q.pop_front();
      if (rx_dat[rx_rd] !== want) begin bad++; $display("FAIL en_rx_data got=%h want=%h", rx_dat[rx_rd], want); end
      rx_rd++;
    end
    total++; if (rd_pulses - rd0 != 1) begin bad++; $display("FAIL en_held_pops got=%0d want=1", rd_pulses - rd0); end
    total++; if (busy !== 1'b0 || fifo_empty !== 1'b0) begin bad++; $display("FAIL en_held_state busy=%b fifo_empty=%b want busy=0 fifo_empty=0", busy, fifo_empty); end
    en = 1'b1;
    wait_frames(1, 200, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL en_resume timeout got=no frame want=77");
    end else begin
      want = exp_q.pop_front();
      if (rx_dat[rx_rd] !== want) begin bad++; $display("FAIL en_resume_data got=%h want=%h", rx_dat[rx_rd], want); end
      rx_rd++;
    end
    repeat (10) @(negedge clk);
    exp_sent += 2;
    total++; if (rd_pulses - rd0 != 2) begin bad++; $display("FAIL en_resume_pops got=%0d want=2", rd_pulses - rd0); end
    total++; if (sent_cnt !== 16'(exp_sent)) begin bad++; $display("FAIL en_sent_cnt got=%0d want=%0d", sent_cnt, exp_sent); end
  endtask

  task automatic test_reset_mid();
    int   rd0;
    bit   ok;
    logic [7:0] want;
    rd0 = rd_pulses;
    push1(8'h3C);
    push1(8'hC3);
    wait_start(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_start timeout got=none want=start bit"); end
    repeat (2 * CPB + 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_abort tx=%b busy=%b want tx=1 busy=0", tx, busy); end
    total++; if (sent_cnt !== 16'h0000) begin bad++; $display("FAIL rstmid_sent_clear got=%0d want=0", sent_cnt); end
    rst = 1'b0;
    void'(exp_q.pop_front());
    exp_sent = 0;
    wait_frames(1, 200, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rstmid_rx timeout got=no frame want=c3");
    end else begin
      want = exp_q.pop_front();
      if (rx_dat[rx_rd] !== want) begin bad++; $display("FAIL rstmid_rx_data got=%h want=%h", rx_dat[rx_rd], want); end
      rx_rd++;
    end
    repeat (10) @(negedge clk);
    exp_sent++;
    total++; if (rd_pulses - rd0 != 2) begin bad++; $display("FAIL rstmid_pops got=%0d want=2", rd_pulses - rd0); end
    total++; if (sent_cnt !== 16'(exp_sent)) begin bad++; $display("FAIL rstmid_sent_cnt got=%0d want=%0d", sent_cnt, exp_sent); end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    bit   ok;
    int   n;
    logic [7:0] want;
    push1(8'hA5);
    push1(8'h07);
    wait_start(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL par_start timeout got=none want=start bit"); end
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (tx_done === 1'b1) break;
    end
    total++; if (n != 44 - 1) begin bad++; $display("FAIL par_frame_len got=%0d want=%0d", n + 1, 44); end
    wait_frames(2, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL par_rx timeout got=%0d want=2 frames", rx_dat.size() - rx_rd); end
    if (ok) begin
      want = exp_q.pop_front();
      total++; if (rx_dat[rx_rd] !== want) begin bad++; $display("FAIL par_data0 got=%h want=%h", rx_dat[rx_rd], want); end
      total++; if (rx_par[rx_rd] !== 1'b0) begin bad++; $display("FAIL par_bit_a5 got=%b want=0", rx_par[rx_rd]); end
      want = exp_q.pop_front();
      total++; if (rx_dat[rx_rd+1] !== want) begin bad++; $display("FAIL par_data1 got=%h want=%h", rx_dat[rx_rd+1], want); end
      total++; if (rx_par[rx_rd+1] !== 1'b1) begin bad++; $display("FAIL par_bit_07 got=%b want=1", rx_par[rx_rd+1]); end
      rx_rd += 2;
    end
    repeat (10) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_en_gate();
    test_reset_mid();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
